f1_light_sequencer: RTL and testbench

F1_LIGHT_SEQUENCER -- requirements
Module: f1_light_sequencer

---
 rtl/f1_pkg.sv | 19 +
 rtl/lfsr16.sv | 19 +
 rtl/f1_light_sequencer.sv | 137 +++++++++++++
 tb/tb_f1_light_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
// Latency: n/a (declarations only); backpressure: n/a.
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STEP_TRIG,
        STEP_WAIT,
        HOLD_TRIG,
        HOLD_WAIT,
        OUT,
        WAIT_RELEASE
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit maximal-length Fibonacci LFSR; advances every cycle.
// Latency: new value each cycle; backpressure: none, never stalls.
module lfsr16
    import f1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/f1_light_sequencer.sv
// F1 start-light sequencer: lights lamps one per STEP_N delay, holds a random time, then blackout.
// Latency: outputs are Moore (1 cycle after the causing edge); backpressure: waits on external delay_timeout.
module f1_light_sequencer
    import f1_pkg::*;
#(
    parameter int               WIDTH     = 14,
    parameter int               LIGHTS    = 5,
    parameter int               STEP_N    = 500,
    parameter int               RAND_MIN  = 250,
    parameter logic [WIDTH-1:0] RAND_MASK = 14'h0FFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              delay_timeout,
    output logic              delay_trigger,
    output logic [WIDTH-1:0]  delay_n,
    output logic [LIGHTS-1:0] lights,
    output logic              lights_out,
    output logic              busy
);

    localparam int CW = $clog2(LIGHTS + 1);

    if (longint'(RAND_MIN) + longint'(RAND_MASK) >= (longint'(1) << WIDTH)) begin : g_err_rand
        $error("RAND_MIN + RAND_MASK must fit in WIDTH bits");
    end
    if (STEP_N <= 0 || longint'(STEP_N) >= (longint'(1) << WIDTH)) begin : g_err_step
        $error("STEP_N must be nonzero and fit in WIDTH bits");
    end
    if (RAND_MIN <= 0) begin : g_err_min
        $error("RAND_MIN must be nonzero");
    end
    if (LIGHTS < 1 || LIGHTS > 16) begin : g_err_lights
        $error("LIGHTS must be in 1..16");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] hold_nxt;
    logic [WIDTH-1:0] hold_calc;
    logic [15:0]      lfsr_q;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // The mask is at most WIDTH bits and RAND_MIN + RAND_MASK fits WIDTH, so no overflow.
    assign hold_calc = WIDTH'(longint'(RAND_MIN) + (longint'(lfsr_q) & longint'(RAND_MASK)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            hold  <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        hold_nxt      = hold;
        delay_trigger = 1'b0;
        delay_n       = '0;
        lights_out    = 1'b0;
        busy          = (state != IDLE);

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = STEP_TRIG;
                end
            end
            STEP_TRIG: begin
                delay_trigger = 1'b1;
                delay_n       = WIDTH'(STEP_N);
                state_nxt     = STEP_WAIT;
            end
            STEP_WAIT: begin
                delay_n = WIDTH'(STEP_N);
                if (delay_timeout) begin
                    count_nxt = count + 1'b1;
                    state_nxt = (count_nxt == CW'(LIGHTS)) ? HOLD_TRIG : STEP_TRIG;
                end
            end
            HOLD_TRIG: begin
                // Same value is driven now and held, so the counter load sees a stable delay_n.
                delay_trigger = 1'b1;
                delay_n       = hold_calc;
                hold_nxt      = hold_calc;
                state_nxt     = HOLD_WAIT;
            end
            HOLD_WAIT: begin
                delay_n = hold;
                if (delay_timeout) begin
                    count_nxt = '0;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                lights_out = 1'b1;
                state_nxt  = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!start) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state != IDLE && abort) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end
    end

    always_comb begin
        lights = '0;
        for (int i = 0; i < LIGHTS; i++) begin
            lights[i] = (count > CW'(i));
        end
    end

endmodule

// File: tb/tb_f1_light_sequencer.sv
// Bench for f1_light_sequencer with a behavioural delay counter and a timeline-based reference model.
// Latency: n/a; backpressure: n/a.
module tb_f1_light_sequencer;

    localparam int               WIDTH     = 14;
    localparam int               LIGHTS    = 5;
    localparam int               STEP_N    = 4;
    localparam int               RAND_MIN  = 3;
    localparam logic [WIDTH-1:0] RAND_MASK = 14'h0003;
    localparam int               P         = STEP_N + 1;
    localparam int               HT        = LIGHTS * P + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              force_to;
    logic              delay_timeout;
    logic              delay_trigger;
    logic [WIDTH-1:0]  delay_n;
    logic [LIGHTS-1:0] lights;
    logic              lights_out;
    logic              busy;

    int          rem;
    logic [15:0] m_lfsr;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          seen [16];

    always #5 clk = ~clk;

    f1_light_sequencer #(
        .WIDTH     (WIDTH),
        .LIGHTS    (LIGHTS),
        .STEP_N    (STEP_N),
        .RAND_MIN  (RAND_MIN),
        .RAND_MASK (RAND_MASK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .delay_timeout (delay_timeout),
        .delay_trigger (delay_trigger),
        .delay_n       (delay_n),
        .lights        (lights),
        .lights_out    (lights_out),
        .busy          (busy)
    );

    // External delay counter: pulses timeout delay_n cycles after the trigger cycle.
    always @(posedge clk) begin
        if (rst) begin
            rem    <= 0;
            m_lfsr <= 16'hACE1;
        end else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            if (delay_trigger) rem <= int'(delay_n);
            else if (rem != 0) rem <= rem - 1;
        end
    end

    assign delay_timeout = (rem == 1) | force_to;

    function automatic logic [31:0] pack(input logic b, input logic t, input logic lo,
                                         input logic [4:0] lt, input logic [13:0] dn);
        return {10'b0, b, t, lo, lt, dn};
    endfunction

    function automatic logic [31:0] outs();
        return pack(busy, delay_trigger, lights_out, lights, delay_n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs from the sequence timeline: c = cycles since start was taken.
    function automatic logic [31:0] model(input int c, input int h, input int a, input int s_low);
        logic b, t, lo;
        logic [4:0]  lt;
        logic [13:0] dn;
        int k, rel;
        b = 0; t = 0; lo = 0; lt = 0; dn = 0;
        if (a == 0 || c <= a) begin
            rel = (HT + h + 2 > s_low) ? HT + h + 2 : s_low;
            if (c <= LIGHTS * P) begin
                k  = (c - 1) / P;
                lt = 5'((1 << k) - 1);
                t  = ((c - 1) % P == 0);
                dn = 14'(STEP_N);
                b  = 1;
            end else if (c <= HT + h) begin
                lt = 5'h1f;
                t  = (c == HT);
                dn = 14'(h);
                b  = 1;
            end else if (c == HT + h + 1) begin
                lo = 1;
                b  = 1;
            end else begin
                b = (c <= rel);
            end
        end
        return pack(b, t, lo, lt, dn);
    endfunction

    // Call at the negedge of an idle cycle; that cycle becomes cycle 0 of the sequence.
    task automatic run_seq(input int L, input int a, output int n_trig, output int n_lout);
        int h, s_low, endc;
        h = 0; n_trig = 0; n_lout = 0;
        s_low = (a != 0 && a < L) ? a : L;
        endc = (a != 0) ? a + 6 : 80;
        start = 1; abort = 0;
        for (int c = 1; c <= endc; c++) begin
            @(negedge clk);
            if (a == 0 && c == HT) begin
                h = RAND_MIN + int'(m_lfsr & 16'(RAND_MASK));
                endc = ((HT + h + 2 > s_low) ? HT + h + 2 : s_low) + 2;
                chk("hold_range", 32'(delay_n >= 3 && delay_n <= 6), 32'd1);
                seen[delay_n[3:0]] = 1'b1;
            end
            chk($sformatf("seq_c%0d", c), outs(), model(c, h, a, s_low));
            chk("lfsr", 32'(dut.u_lfsr.q), 32'(m_lfsr));
            chk("lfsr_nonzero", 32'(dut.u_lfsr.q != 16'h0), 32'd1);
            n_trig += int'(delay_trigger);
            n_lout += int'(lights_out);
            start = (c < s_low);
            abort = (c == a);
        end
        start = 0; abort = 0;
    endtask

    typedef struct {
        logic        rst, start, abort, tmo;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nt, nl, nd, L, a;
        rst = 1; start = 0; abort = 0; force_to = 0;

        // Reset, spurious timeouts in IDLE/STEP_TRIG, abort priority, first step, abort.
        tbl[0]  = '{1, 0, 0, 0, pack(0, 0, 0, 5'h00, 14'd0)};
        tbl[1]  = '{1, 1, 0, 1, pack(0, 0, 0, 5'h00, 14'd0)};
        tbl[2]  = '{0, 0, 0, 1, pack(0, 0, 0, 5'h00, 14'd0)};
        tbl[3]  = '{0, 1, 1, 0, pack(0, 0, 0, 5'h00, 14'd0)};
        tbl[4]  = '{0, 1, 0, 1, pack(1, 1, 0, 5'h00, 14'd4)};
        tbl[5]  = '{0, 1, 0, 1, pack(1, 0, 0, 5'h00, 14'd4)};
        tbl[6]  = '{0, 0, 0, 0, pack(1, 0, 0, 5'h00, 14'd4)};
        tbl[7]  = '{0, 0, 0, 0, pack(1, 0, 0, 5'h00, 14'd4)};
        tbl[8]  = '{0, 0, 0, 0, pack(1, 0, 0, 5'h00, 14'd4)};
        tbl[9]  = '{0, 0, 0, 0, pack(1, 1, 0, 5'h01, 14'd4)};
        tbl[10] = '{0, 0, 1, 0, pack(0, 0, 0, 5'h00, 14'd0)};
        tbl[11] = '{0, 0, 0, 0, pack(0, 0, 0, 5'h00, 14'd0)};
        tbl[12] = '{0, 0, 0, 0, pack(0, 0, 0, 5'h00, 14'd0)};
        tbl[13] = '{0, 0, 0, 0, pack(0, 0, 0, 5'h00, 14'd0)};
        tbl[14] = '{0, 0, 0, 0, pack(0, 0, 0, 5'h00, 14'd0)};

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort; force_to = tbl[i].tmo;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end
        rst = 0; start = 0; abort = 0; force_to = 0;
        @(negedge clk);

        // Full sequence: 5 step triggers plus the hold trigger, one blackout pulse.
        run_seq(2, 0, nt, nl);
        chk("full_triggers", 32'(nt), 32'd6);
        chk("full_lights_out", 32'(nl), 32'd1);

        // Start held through blackout, then released and re-pressed.
        run_seq(40, 0, nt, nl);
        chk("held_lights_out", 32'(nl), 32'd1);
        run_seq(3, 0, nt, nl);
        chk("restart_lights_out", 32'(nl), 32'd1);

        // Abort with 3 lights lit, coinciding with a step timeout.
        run_seq(30, 4 * P, nt, nl);
        chk("abort_triggers", 32'(nt), 32'd4);
        chk("abort_lights_out", 32'(nl), 32'd0);

        // Reset during HOLD_WAIT.
        start = 1;
        for (int c = 1; c <= HT + 1; c++) begin
            @(negedge clk);
            start = 0;
        end
        chk("midrst_pre", {30'b0, busy, &lights}, 32'd3);
        rst = 1;
        @(negedge clk);
        chk("midrst_outs", outs(), 32'd0);
        chk("midrst_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        for (int s = 0; s < 64; s++) begin
            L = int'($urandom_range(1, 40));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LIGHTS * P)) : 0;
            run_seq(L, a, nt, nl);
            chk("rand_lights_out", 32'(nl), (a == 0) ? 32'd1 : 32'd0);
        end
        nd = 0;
        for (int i = 0; i < 16; i++) nd += int'(seen[i]);
        chk("distinct_holds", 32'(nd >= 3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
